blink_rate_ctrl: RTL

Upstream control stage for the runtime-programmable clock divider in the variable-blink design. Two push buttons step the blink rate.
- Faster halves the divider value.
- Slower doubles it.
The block synchronises and debounces both buttons, auto-repeats while a button is held, and saturates the value between limits. Its `divider` output connects directly to the divider's 32-bit divider input.

---
 rtl/blink_rate_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/blink_rate_ctrl.sv
// blink_rate_ctrl: two-button rate control for the blink clock divider.
// Sync, debounce, auto-repeat and saturating halve/double of the divider.
module blink_rate_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_CYCLES   = 6000000,
  parameter logic [31:0] DIV_MIN         = 32'd2,
  parameter logic [31:0] DIV_MAX         = 32'd48000000,
  parameter logic [31:0] DIV_INIT        = 32'd12000000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        btn_faster,
  input  logic        btn_slower,
  output logic [31:0] divider,
  output logic        changed
);

  // Counter widths only need to hold 0 .. N-1.
  localparam int unsigned DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RP_W =
    (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_LAST =
    RP_W'(REPEAT_CYCLES - 1);

  // Bit 0 is the faster button, bit 1 the slower one.
  logic [1:0]      btn_raw;

  logic [1:0]      sync1_q;
  logic [1:0]      sync1_d;
  logic [1:0]      sync2_q;
  logic [1:0]      sync2_d;

  logic [1:0]      deb_q;
  logic [1:0]      deb_d;
  logic [1:0]      deb_prev_q;
  logic [1:0]      deb_prev_d;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [DB_W-1:0] db_cnt_d [2];

  logic [1:0]      deb_swap;
  logic [1:0]      run;
  logic [1:0]      press;
  logic [1:0]      tick;
  logic [1:0]      step;
  logic [RP_W-1:0] rep_cnt_q [2];
  logic [RP_W-1:0] rep_cnt_d [2];

  logic [31:0]     div_q;
  logic [31:0]     div_d;
  logic            chg_q;
  logic            chg_d;
  logic [31:0]     div_half;
  logic [32:0]     div_dbl;
  logic [31:0]     div_nxt;
  logic            fast_only;
  logic            slow_only;

  assign btn_raw = {btn_slower, btn_faster};

  // Two-flop synchroniser next state.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  // Debounce: flip after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d      = deb_q;
    deb_prev_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Press edges and auto-repeat ticks; a held button blocks the
  // other's repeat, and the press cycle restarts the repeat count.
  always_comb begin
    deb_swap = {deb_q[0], deb_q[1]};
    run      = deb_q & ~deb_swap;
    press    = deb_q & ~deb_prev_q;
    tick     = '0;
    for (int i = 0; i < 2; i++) begin
      rep_cnt_d[i] = '0;
      if (run[i] && !press[i]) begin
        if (rep_cnt_q[i] == RP_LAST) begin
          tick[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
        end
      end
    end
    step = press | tick;
  end

  // Auto-repeat counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rep_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // Saturating halve/double; simultaneous steps cancel out.
  always_comb begin
    fast_only = step[0] & ~step[1];
    slow_only = step[1] & ~step[0];
    div_half  = {1'b0, div_q[31:1]};
    div_dbl   = {div_q, 1'b0};
    div_nxt   = div_q;
    unique case (1'b1)
      fast_only: begin
        div_nxt = (div_half < DIV_MIN) ? DIV_MIN : div_half;
      end
      slow_only: begin
        div_nxt = (div_dbl > {1'b0, DIV_MAX}) ?
                  DIV_MAX : div_dbl[31:0];
      end
      default: begin
        div_nxt = div_q;
      end
    endcase
    div_d = div_nxt;
    chg_d = (div_nxt != div_q);
  end

  // Registered divider value and change pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_q <= DIV_INIT;
      chg_q <= 1'b0;
    end else begin
      div_q <= div_d;
      chg_q <= chg_d;
    end
  end

  assign divider = div_q;
  assign changed = chg_q;

endmodule
